// File: rtl/exec_stage.sv
// Execute stage: single-issue ALU with an 8-cycle shift-add multiplier and a
// one-cycle register-file writeback.
module exec_stage (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [2:0] destReg,
  input  logic [7:0] regA,
  input  logic [7:0] regB,
  output logic       busy,
  output logic       enableWrite,
  output logic [2:0] registerWrite,
  output logic [7:0] dataIn,
  output logic       flagZero,
  output logic       flagCarry
);

  typedef enum logic [1:0] {IDLE, EXEC, MULT, WB} state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  dst_q, dst_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] acc_q, acc_d;
  logic        we_q, we_d;
  logic [2:0]  wr_idx_q, wr_idx_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;

  logic [8:0]  sum;
  logic [8:0]  diff;
  logic [8:0]  shl_w;
  logic [15:0] prod_next;
  logic [7:0]  alu_res;
  logic        alu_carry;

  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = {1'b0, a_q} - {1'b0, b_q};
    // bit 8 of the widened shift is the last bit pushed out (0 for shift 0)
    shl_w     = {1'b0, a_q} << b_q[2:0];
    prod_next = acc_q + (b_q[cnt_q] ? ({8'h00, a_q} << cnt_q) : 16'h0000);
    alu_res   = a_q;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin alu_res = sum[7:0];   alu_carry = sum[8];   end
      OP_SUB: begin alu_res = diff[7:0];  alu_carry = diff[8];  end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: begin alu_res = shl_w[7:0]; alu_carry = shl_w[8]; end
      default: alu_res = a_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dst_d     = dst_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    we_d      = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = opcode;
          dst_d   = destReg;
          a_d     = regA;
          b_d     = regB;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = (opcode == OP_MUL) ? MULT : EXEC;
        end
      end
      EXEC: begin
        state_d   = WB;
        we_d      = (dst_q != 3'd0);
        wr_idx_d  = dst_q;
        wr_data_d = alu_res;
        zero_d    = (alu_res == 8'h00);
        carry_d   = alu_carry;
      end
      MULT: begin
        acc_d = prod_next;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d   = WB;
          we_d      = (dst_q != 3'd0);
          wr_idx_d  = dst_q;
          wr_data_d = prod_next[7:0];
          zero_d    = (prod_next[7:0] == 8'h00);
          carry_d   = (prod_next[15:8] != 8'h00);
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      dst_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      we_q      <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      we_q      <= we_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign enableWrite   = we_q;
  assign registerWrite = wr_idx_q;
  assign dataIn        = wr_data_q;
  assign flagZero      = zero_q;
  assign flagCarry     = carry_q;

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 The block SHALL have these ports, one per line (name, direction, width, meaning), clock and reset first.
  clock          input   1  single clock; all state updates on rising edge
  reset          input   1  synchronous, active-high reset
  start          input   1  request to execute one instruction; sampled only in IDLE
  opcode         input   3  operation select (REQ-010)
  destReg        input   3  destination register index
  regA           input   8  operand A from register file read port A
  regB           input   8  operand B from register file read port B
  busy           output  1  high whenever state is not IDLE
  enableWrite    output  1  register-file write strobe, one cycle wide
  registerWrite  output  3  register-file write index
  dataIn         output  8  register-file write data
  flagZero       output  1  result == 0, last completed op
  flagCarry      output  1  carry/borrow/overflow, last completed op
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-003 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-004 The block SHALL implement states IDLE, EXEC, MULT, WB.
REQ-005 In IDLE with start=1, the block SHALL latch opcode, destReg, regA, and regB at that edge, then go to MULT if opcode=110 and to EXEC otherwise.
REQ-006 In IDLE with start=0, the block SHALL remain in IDLE; start SHALL be ignored in every other state, with no queuing.
REQ-007 EXEC SHALL last exactly one cycle, compute the result from the latched operands into registered outputs, and go to WB.
REQ-008 MULT SHALL last exactly 8 cycles as an iterative shift-add over a 16-bit accumulator with a 3-bit counter 0..7. On each iteration, if B[i]=1, it SHALL add A<<i. After iteration 7 it SHALL go to WB.
REQ-009 WB SHALL last exactly one cycle: enableWrite=1 unless the latched destReg=0, registerWrite=latched destReg, and dataIn=result. The next state SHALL be IDLE.
REQ-010 Opcodes SHALL be as follows.
  000 ADD: {carry,result} = A+B
  001 SUB: result = A-B; carry = borrow (A<B)
  010 AND
  011 OR
  100 XOR
  101 SHL: A << B[2:0]; carry = last bit shifted out, 0 if shift=0
  110 MUL: result = product[7:0]; carry = (product[15:8] != 0)
  111 PASS: result = A
  For AND, OR, XOR and PASS, carry SHALL be 0.
REQ-011 flagZero and flagCarry SHALL update on the edge entering WB and hold until the next op reaches WB.
REQ-012 Latency SHALL be: start edge to WB cycle = 2 cycles for non-MUL ops and 9 cycles for MUL.
REQ-013 busy SHALL be 1 in EXEC, MULT, and WB. A new start SHALL be accepted in the IDLE cycle immediately after WB, so back-to-back throughput = 1 op per 3 cycles (non-MUL).
REQ-014 enableWrite SHALL be 0 in every state except WB.
REQ-015 registerWrite and dataIn SHALL hold their last values outside WB; consumers qualify them with enableWrite only.
REQ-016 Operand changes on regA/regB after the accepting edge SHALL NOT affect the result, so writeback to a source register is safe.
REQ-017 destReg=0 SHALL still execute the op and update the flags, but SHALL NOT assert enableWrite.

Reset
REQ-018 With reset=1 at a rising edge, the block SHALL go to IDLE and set busy=0, enableWrite=0, registerWrite=0, dataIn=0, flagZero=0, flagCarry=0, and clear the counter and accumulator.
REQ-019 Reset SHALL take priority over start and over any in-flight op.
REQ-020 Reset asserted during EXEC, MULT, or WB SHALL abort the op with no write strobe generated, including when reset coincides with WB.

Verification
REQ-021 ADD regA=0xF0, regB=0x20, destReg=3 -> 2 cycles later enableWrite=1, registerWrite=3, dataIn=0x10, flagCarry=1, flagZero=0.
REQ-022 SUB regA=0x05, regB=0x05, destReg=1 -> dataIn=0x00, flagZero=1, flagCarry=0; then SUB 0x03-0x04 -> dataIn=0xFF, flagCarry=1.
REQ-023 MUL regA=0x13, regB=0x0E, destReg=7 -> busy held 9 cycles, single WB pulse with dataIn=0x0A, flagCarry=1 (product 0x010A); start pulses during MULT are ignored.
REQ-024 SHL regA=0x81, regB=0x01, destReg=2 -> dataIn=0x02, flagCarry=1; PASS with destReg=0 -> no enableWrite, flags still updated.
REQ-025 Reset asserted in the 4th MULT cycle -> next cycle busy=0, no enableWrite ever pulses, all outputs 0; a new ADD 0x01+0x01 then completes with dataIn=0x02.
REQ-026 Change regA/regB every cycle after accepting ADD 0x10+0x01 -> result is 0x11; start held high continuously -> one op accepted per 3 cycles.
